hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_pkg.sv | 14 +
 rtl/hex7seg_decode.sv | 11 +
 rtl/hex_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_hex_scan_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// hex_scan_pkg: shared types, constants and seven-segment decode table for hex_scan_ctrl
//   PH_GAP/PH_ON : scan phase (all-off dead time / digit driven)
//   OWN_CPU/OWN_HW : which source owns the current frame
//   SEG_BLANK : active-low all-segments-off pattern
//   SEG_TABLE : active-low {g,f,e,d,c,b,a} pattern per hex nibble, entry 0 at the LSB end
package hex_scan_pkg;
    typedef enum logic {PH_GAP, PH_ON} phase_e;
    typedef enum logic {OWN_CPU, OWN_HW} owner_e;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex nibble to active-low seven-segment pattern
//   nibble_i : 4-bit hex digit
//   seg_n_o  : active-low segments {g,f,e,d,c,b,a}
module hex7seg_decode
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);
    assign seg_n_o = SEG_TABLE[nibble_i];
endmodule

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed seven-segment scanner with per-frame CPU/HW source arbitration
//   clk_i        : system clock
//   reset_i      : synchronous active-high reset
//   cpu_value_i  : CPU PIO value, nibble k shown on digit k
//   hw_req_i     : hardware debug source requests the display
//   hw_value_i   : hardware debug value
//   blank_mask_i : bit k set blanks digit k
//   hw_grant_o   : hardware source owns the current frame
//   seg_n_o      : active-low segments {g,f,e,d,c,b,a}
//   dig_sel_n_o  : active-low digit enables, at most one low
//   frame_done_o : one-cycle pulse during the last ON cycle of the last digit
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [4*NUM_DIGITS-1:0] cpu_value_i,
    input  logic                    hw_req_i,
    input  logic [4*NUM_DIGITS-1:0] hw_value_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
    output logic                    hw_grant_o,
    output logic [6:0]              seg_n_o,
    output logic [NUM_DIGITS-1:0]   dig_sel_n_o,
    output logic                    frame_done_o
);
    localparam int VW   = 4 * NUM_DIGITS;
    localparam int CMAX = ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    phase_e                phase_q, phase_d;
    owner_e                owner_q, owner_d;
    logic                  start_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         snap_q, snap_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_done_q, frame_done_d;
    logic                  boundary;
    logic                  show;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;

    // start_q marks the first edge after reset, which is itself a frame boundary
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (start_q) begin
            phase_d  = PH_GAP;
            cnt_d    = '0;
            idx_d    = '0;
            boundary = 1'b1;
        end else if (phase_q == PH_GAP) begin
            if (cnt_q == GAP_LAST) begin
                phase_d = PH_ON;
                cnt_d   = '0;
            end
        end else if (cnt_q == ON_LAST) begin
            phase_d  = PH_GAP;
            cnt_d    = '0;
            idx_d    = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
            boundary = idx_q == IDX_LAST;
        end
        owner_d = boundary ? (hw_req_i ? OWN_HW : OWN_CPU) : owner_q;
        snap_d  = boundary ? (hw_req_i ? hw_value_i : cpu_value_i) : snap_q;
        mask_d  = boundary ? blank_mask_i : mask_q;
    end

    // outputs are registered from next-state so the display tracks the phase with no extra lag
    assign nibble = snap_d[{idx_d, 2'b00} +: 4];

    hex7seg_decode u_dec (
        .nibble_i (nibble),
        .seg_n_o  (dec_seg)
    );

    always_comb begin
        show         = phase_d == PH_ON && !mask_d[idx_d];
        seg_d        = show ? dec_seg : SEG_BLANK;
        dig_d        = show ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        frame_done_d = phase_d == PH_ON && idx_d == IDX_LAST && cnt_d == ON_LAST;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            start_q      <= 1'b1;
            phase_q      <= PH_GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            owner_q      <= OWN_CPU;
            snap_q       <= '0;
            mask_q       <= '0;
            seg_q        <= SEG_BLANK;
            dig_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            owner_q      <= owner_d;
            snap_q       <= snap_d;
            mask_q       <= mask_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hw_grant_o   = owner_q == OWN_HW;
    assign seg_n_o      = seg_q;
    assign dig_sel_n_o  = dig_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: scoreboard bench for hex_scan_ctrl with ON_CYCLES=4, GAP_CYCLES=1
module tb_hex_scan_ctrl;
    localparam int FRAME = 30;
    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int         k;
        logic [6:0] seg;
        int         t_start;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] cpu_value = 24'h123456;
    logic        hw_req = 1'b0;
    logic [23:0] hw_value = 24'h0;
    logic [5:0]  blank_mask = 6'h0;
    logic        hw_grant;
    logic [6:0]  seg_n;
    logic [5:0]  dig_sel_n;
    logic        frame_done;

    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    exp_t q[$];

    hex_scan_ctrl #(.NUM_DIGITS(6), .ON_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cpu_value_i  (cpu_value),
        .hw_req_i     (hw_req),
        .hw_value_i   (hw_value),
        .blank_mask_i (blank_mask),
        .hw_grant_o   (hw_grant),
        .seg_n_o      (seg_n),
        .dig_sel_n_o  (dig_sel_n),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // t counts edges since reset release; every FRAME-th edge is a boundary whose
    // captured inputs determine the digit windows of the coming frame
    initial begin
        logic [23:0] src;
        exp_t        ex;
        forever begin
            @(posedge clk);
            if (reset) begin
                t = 0;
                q.delete();
            end else begin
                if (t % FRAME == 0) begin
                    src = hw_req ? hw_value : cpu_value;
                    for (int k = 0; k < 6; k++)
                        if (!blank_mask[k]) begin
                            ex.k       = k;
                            ex.seg     = DEC[src[4*k +: 4]];
                            ex.t_start = t + 1 + 5 * k;
                            q.push_back(ex);
                        end
                end
                t++;
            end
        end
    end

    initial begin
        logic [5:0] prev;
        logic [6:0] wseg;
        int         wlen, e, k;
        exp_t       ex;
        prev = '1;
        wlen = 0;
        wseg = '0;
        forever begin
            @(negedge clk);
            if (t == 0) begin
                prev = '1;
                wlen = 0;
            end else begin
                e = t - 1;
                checks++;
                if (frame_done !== (e % FRAME == FRAME - 1)) begin
                    errors++;
                    $display("FAIL mon_frame_done edge=%0d got=%b exp=%b", e, frame_done, e % FRAME == FRAME - 1);
                end
                if (dig_sel_n !== '1) begin
                    checks++;
                    if ($countones(~dig_sel_n) != 1 || (prev !== '1 && dig_sel_n !== prev)) begin
                        errors++;
                        $display("FAIL mon_dig_sel edge=%0d got=%b prev=%b exp=one low after all-ones", e, dig_sel_n, prev);
                    end
                    if (prev === '1) begin
                        k = 0;
                        for (int i = 0; i < 6; i++)
                            if (!dig_sel_n[i]) k = i;
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL mon_unexpected_window edge=%0d got=digit %0d exp=none", e, k);
                        end else begin
                            ex = q.pop_front();
                            if (ex.k != k || ex.seg !== seg_n || ex.t_start != e) begin
                                errors++;
                                $display("FAIL mon_window got=digit %0d seg %h edge %0d exp=digit %0d seg %h edge %0d",
                                         k, seg_n, e, ex.k, ex.seg, ex.t_start);
                            end
                        end
                        wlen = 1;
                        wseg = seg_n;
                    end else begin
                        wlen++;
                        checks++;
                        if (seg_n !== wseg) begin
                            errors++;
                            $display("FAIL mon_seg_stable edge=%0d got=%h exp=%h", e, seg_n, wseg);
                        end
                    end
                end else if (prev !== '1) begin
                    checks++;
                    if (wlen != 4) begin
                        errors++;
                        $display("FAIL mon_window_len edge=%0d got=%0d exp=4", e, wlen);
                    end
                end
                prev = dig_sel_n;
            end
        end
    end

    task automatic goto_pos(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((t - 1) % FRAME) != p && n < 100);
        if (((t - 1) % FRAME) != p) begin
            errors++;
            $display("FAIL goto_pos got=%0d exp=%0d", (t - 1) % FRAME, p);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
        if (dig_sel_n !== 6'h3F) begin errors++; $display("FAIL reset_dig got=%b exp=111111", dig_sel_n); end
        if (hw_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", hw_grant); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    endtask

    task automatic test_cpu_scan();
        int pulses[$];
        cpu_value = 24'h123456;
        hw_req = 1'b0;
        reset = 1'b0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            if (e == 0) begin
                checks++;
                if (dig_sel_n !== 6'h3F) begin errors++; $display("FAIL scan_first_gap got=%b exp=111111", dig_sel_n); end
            end
            if (e >= 1 && e <= 4) begin
                checks++;
                if (dig_sel_n !== 6'b111110 || seg_n !== 7'h02) begin
                    errors++;
                    $display("FAIL scan_digit0 e=%0d got=%b/%h exp=111110/02", e, dig_sel_n, seg_n);
                end
            end
            if (e == 26) begin
                checks++;
                if (dig_sel_n !== 6'b011111 || seg_n !== 7'h79) begin
                    errors++;
                    $display("FAIL scan_digit5 got=%b/%h exp=011111/79", dig_sel_n, seg_n);
                end
            end
            if (frame_done) pulses.push_back(e);
        end
        checks++;
        if (pulses.size() != 2 || pulses[0] != 29 || pulses[1] != 59) begin
            errors++;
            $display("FAIL scan_frame_done got=%0d pulses exp=2 at 29,59", pulses.size());
        end
    endtask

    task automatic test_hw_takeover();
        goto_pos(10);
        hw_value = 24'hABCDEF;
        hw_req = 1'b1;
        goto_pos(26);
        checks++;
        if (hw_grant !== 1'b0 || seg_n !== 7'h79) begin
            errors++;
            $display("FAIL hw_frame_not_torn got=%b/%h exp=0/79", hw_grant, seg_n);
        end
        goto_pos(1);
        checks++;
        if (hw_grant !== 1'b1 || dig_sel_n !== 6'b111110 || seg_n !== 7'h0E) begin
            errors++;
            $display("FAIL hw_granted got=%b/%b/%h exp=1/111110/0e", hw_grant, dig_sel_n, seg_n);
        end
        goto_pos(12);
        hw_req = 1'b0;
        goto_pos(29);
        checks++;
        if (hw_grant !== 1'b1) begin errors++; $display("FAIL hw_grant_hold got=%b exp=1", hw_grant); end
        goto_pos(1);
        checks++;
        if (hw_grant !== 1'b0 || seg_n !== 7'h02) begin
            errors++;
            $display("FAIL hw_release got=%b/%h exp=0/02", hw_grant, seg_n);
        end
    endtask

    task automatic test_no_tear();
        goto_pos(25);
        cpu_value = 24'h000000;
        goto_pos(11);
        cpu_value = 24'hFFFFFF;
        for (int d = 3; d < 6; d++) begin
            goto_pos(1 + 5 * d);
            checks++;
            if (dig_sel_n[d] !== 1'b0 || seg_n !== 7'h40) begin
                errors++;
                $display("FAIL no_tear_digit%0d got=%b/%h exp=low/40", d, dig_sel_n[d], seg_n);
            end
        end
        goto_pos(1);
        checks++;
        if (seg_n !== 7'h0E) begin errors++; $display("FAIL no_tear_next got=%h exp=0e", seg_n); end
        cpu_value = 24'h123456;
    endtask

    task automatic test_blank();
        int  pulses[$];
        logic lit = 1'b0;
        goto_pos(2);
        blank_mask = 6'b100001;
        goto_pos(29);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!dig_sel_n[0] || !dig_sel_n[5]) lit = 1'b1;
            if (frame_done) pulses.push_back(i);
        end
        checks += 2;
        if (lit) begin errors++; $display("FAIL blank_lit got=lit exp=dark"); end
        if (pulses.size() != 2 || pulses[0] != 29 || pulses[1] != 59) begin
            errors++;
            $display("FAIL blank_frame_done got=%0d pulses exp=2 at 29,59", pulses.size());
        end
        blank_mask = 6'h0;
    endtask

    task automatic test_reset_mid();
        goto_pos(2);
        hw_value = 24'h000000;
        hw_req = 1'b1;
        goto_pos(0);
        goto_pos(16);
        checks++;
        if (hw_grant !== 1'b1 || dig_sel_n !== 6'b110111) begin
            errors++;
            $display("FAIL rst_mid_pre got=%b/%b exp=1/110111", hw_grant, dig_sel_n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dig_sel_n !== 6'h3F || hw_grant !== 1'b0 || seg_n !== 7'h7F || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got=%b/%b/%h/%b exp=111111/0/7f/0", dig_sel_n, hw_grant, seg_n, frame_done);
        end
        reset = 1'b0;
        hw_req = 1'b0;
        cpu_value = 24'h123456;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            checks++;
            if ((e >= 1 && e <= 4) ? (dig_sel_n !== 6'b111110 || seg_n !== 7'h02) : (dig_sel_n !== 6'h3F)) begin
                errors++;
                $display("FAIL rst_restart e=%0d got=%b/%h", e, dig_sel_n, seg_n);
            end
        end
    endtask

    task automatic test_continuous();
        logic [5:0] prev = 6'h3F;
        int         pulses = 0;
        goto_pos(29);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if ($countones(~dig_sel_n) > 1 || (prev !== 6'h3F && dig_sel_n !== 6'h3F && dig_sel_n !== prev)) begin
                errors++;
                $display("FAIL cont_dig_sel i=%0d got=%b prev=%b", i, dig_sel_n, prev);
            end
            prev = dig_sel_n;
            if (frame_done) pulses++;
            if (i % 7 == 0) begin
                cpu_value = 24'($urandom);
                hw_value = 24'($urandom);
                hw_req = 1'($urandom_range(1));
            end
        end
        checks++;
        if (pulses != 10) begin errors++; $display("FAIL cont_frames got=%0d exp=10", pulses); end
    endtask

    initial begin
        test_reset();
        test_cpu_scan();
        test_hw_takeover();
        test_no_tear();
        test_blank();
        test_reset_mid();
        test_continuous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
